// File: rtl/load_reload_sched_if.sv
// Requester/engine bundle for load_reload_sched.
//   req        requester -> scheduler   level request per requester
//   grant      scheduler -> requester   one-hot owner of the load engine
//   ack        scheduler -> requester   one-cycle completion pulse to the owner
//   fail       scheduler -> requester   valid with ack, 1 = all attempts failed
//   retries    scheduler -> requester   reloads used, valid with ack
//   load_start scheduler -> engine      one-cycle pulse, engine begins an attempt
//   load_done  engine -> scheduler      current attempt finished
//   load_err   engine -> scheduler      qualifies load_done, attempt failed
//   control    scheduler -> observer    one-hot state register
// master = requester/engine side, slave = scheduler side.
interface load_reload_sched_if #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_RELOADS = 2
);
    localparam int RW = $clog2(MAX_RELOADS + 1);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ack;
    logic               fail;
    logic [RW-1:0]      retries;
    logic               load_start;
    logic               load_done;
    logic               load_err;
    logic [3:0]         control;

    modport master (
        output req, load_done, load_err,
        input  grant, ack, fail, retries, load_start, control
    );

    modport slave (
        input  req, load_done, load_err,
        output grant, ack, fail, retries, load_start, control
    );
endinterface

// File: rtl/load_reload_sched.sv
// Round-robin scheduler sharing one load engine among NUM_REQ requesters.
// Each grant walks WAITE -> LOAD (-> RELOAD -> LOAD)* -> DONE -> WAITE.
// A failed or timed-out attempt is retried up to MAX_RELOADS times after a
// RELOAD_GAP idle period; the owner then receives an ack with fail/retries.
// Ports:
//   clock   rising-edge clock
//   resetN  synchronous reset, active low
//   bus     slave side of load_reload_sched_if (requests, grant/ack, engine handshake)
module load_reload_sched #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_RELOADS = 2,
    parameter int RELOAD_GAP  = 3,
    parameter int TIMEOUT     = 16
) (
    input  logic                 clock,
    input  logic                 resetN,
    load_reload_sched_if.slave   bus
);
    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RW   = $clog2(MAX_RELOADS + 1);
    localparam int TMAX = (TIMEOUT > RELOAD_GAP) ? TIMEOUT : RELOAD_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);
    localparam logic [PW:0]        NREQ     = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0]      LAST     = PW'(NUM_REQ - 1);
    localparam logic [RW-1:0]      MAXR     = RW'(MAX_RELOADS);
    localparam logic [TW-1:0]      TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]      GAP_LAST = TW'(RELOAD_GAP - 1);

    typedef enum logic [3:0] {
        WAITE  = 4'b0001,
        LOAD   = 4'b0010,
        RELOAD = 4'b0100,
        DONE   = 4'b1000
    } state_t;

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      owner;
    logic [RW-1:0]      tries;
    logic [TW-1:0]      timer;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               fail_q;
    logic               start_q;

    logic [PW-1:0]      pick_idx;
    logic               pick_vld;
    logic [PW:0]        cand;

    // First requester at or after the RR pointer, scanning with wrap-around.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= NREQ)
                cand = cand - NREQ;
            if (!pick_vld && bus.req[cand[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[PW-1:0];
            end
        end
    end

    // timer counts LOAD cycles within an attempt, then RELOAD gap cycles.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state   <= WAITE;
            ptr     <= '0;
            owner   <= '0;
            tries   <= '0;
            timer   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            fail_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            ack_q   <= '0;
            case (state)
                WAITE: begin
                    if (pick_vld) begin
                        state   <= LOAD;
                        owner   <= pick_idx;
                        grant_q <= ONE << pick_idx;
                        start_q <= 1'b1;
                        tries   <= '0;
                        timer   <= '0;
                    end
                end
                LOAD: begin
                    if (bus.load_done && !bus.load_err) begin
                        state  <= DONE;
                        ack_q  <= grant_q;
                        fail_q <= 1'b0;
                    end else if ((bus.load_done && bus.load_err) || timer == TO_LAST) begin
                        if (tries < MAXR) begin
                            state <= RELOAD;
                            tries <= tries + 1'b1;
                            timer <= '0;
                        end else begin
                            state  <= DONE;
                            ack_q  <= grant_q;
                            fail_q <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RELOAD: begin
                    if (timer == GAP_LAST) begin
                        state   <= LOAD;
                        start_q <= 1'b1;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    state   <= WAITE;
                    grant_q <= '0;
                    fail_q  <= 1'b0;
                    ptr     <= (owner == LAST) ? '0 : owner + 1'b1;
                end
                default: begin
                    // corrupted state register: drop everything and go idle
                    state   <= WAITE;
                    grant_q <= '0;
                    fail_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.ack        = ack_q;
    assign bus.fail       = fail_q;
    assign bus.retries    = tries;
    assign bus.load_start = start_q;
    assign bus.control    = state;
endmodule

// File: tb/tb_load_reload_sched.sv
// Bench for load_reload_sched: a transaction-level planner predicts the full
// per-cycle output trace of each grant; a negedge process compares it to the DUT.
module tb_load_reload_sched;
    localparam int N    = 4;
    localparam int MAXR = 2;
    localparam int GAP  = 3;
    localparam int TO   = 16;
    localparam int RW   = $clog2(MAXR + 1);

    localparam logic [3:0] C_WAITE  = 4'b0001;
    localparam logic [3:0] C_LOAD   = 4'b0010;
    localparam logic [3:0] C_RELOAD = 4'b0100;
    localparam logic [3:0] C_DONE   = 4'b1000;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    load_reload_sched_if #(.NUM_REQ(N), .MAX_RELOADS(MAXR)) bus();

    load_reload_sched #(
        .NUM_REQ(N), .MAX_RELOADS(MAXR), .RELOAD_GAP(GAP), .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .resetN(resetN),
        .bus(bus)
    );

    typedef struct packed {
        logic [3:0]    ctl;
        logic [N-1:0]  grant;
        logic [N-1:0]  ack;
        logic          ls;
        logic          fail;
        logic [RW-1:0] retries;
        logic          chk_fr;
    } exp_t;

    exp_t expv;
    bit   chk_en = 0;
    int   checks = 0;
    int   errors = 0;
    int   ptr_m  = 0;

    int ls_cnt, reload_cyc, load_cyc, ack_cnt;
    int last_ack, last_fail, last_retries;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req_v, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("control", 32'(bus.control), 32'(expv.ctl));
            chk("grant", 32'(bus.grant), 32'(expv.grant));
            chk("ack", 32'(bus.ack), 32'(expv.ack));
            chk("load_start", 32'(bus.load_start), 32'(expv.ls));
            if (expv.chk_fr) begin
                chk("fail", 32'(bus.fail), 32'(expv.fail));
                chk("retries", 32'(bus.retries), 32'(expv.retries));
            end
            if (bus.load_start === 1'b1) ls_cnt++;
            if (bus.control === C_RELOAD) reload_cyc++;
            if (bus.control === C_LOAD) load_cyc++;
            if (|bus.ack) begin
                ack_cnt++;
                last_ack     = int'(bus.ack);
                last_fail    = int'(bus.fail);
                last_retries = int'(bus.retries);
            end
        end
    end

    function automatic exp_t mk(input logic [3:0] c, input logic [N-1:0] g, input logic [N-1:0] a,
                                input logic ls, input logic f, input int rt, input logic fr);
        exp_t e;
        e.ctl = c; e.grant = g; e.ack = a; e.ls = ls; e.fail = f;
        e.retries = RW'(rt); e.chk_fr = fr;
        return e;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [N-1:0] rreq();
        return N'($urandom_range(0, (1 << N) - 1));
    endfunction

    // One clock: drive inputs, take the edge, publish what the DUT must now show.
    task automatic step(input logic rst_n, input logic [N-1:0] r, input logic d,
                        input logic e, input exp_t ex);
        resetN = rst_n; bus.req = r; bus.load_done = d; bus.load_err = e;
        @(posedge clock);
        #1;
        expv = ex;
        chk_en = 1;
    endtask

    task automatic clear_cnt();
        ls_cnt = 0; reload_cyc = 0; load_cyc = 0; ack_cnt = 0;
        last_ack = -1; last_fail = -1; last_retries = -1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, '1, rb(), rb(), mk(C_WAITE, '0, '0, 1'b0, 1'b0, 0, 1'b1));
        ptr_m = 0;
    endtask

    // mode: 0 success, 1 error every attempt, 2 never done, 3 random per attempt.
    // abort_at: step index within the grant at which reset is applied (0 = never).
    task automatic run_txn(input logic [N-1:0] r, input int mode, input int dly, input int abort_at);
        int owner, k, outc, d, len;
        logic [N-1:0] g;
        if (r == '0) begin
            step(1'b1, r, rb(), rb(), mk(C_WAITE, '0, '0, 1'b0, 1'b0, 0, 1'b0));
            return;
        end
        owner = -1;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (ptr_m + i) % N;
            if (owner < 0 && r[idx]) owner = idx;
        end
        g = '0;
        g[owner] = 1'b1;
        step(1'b1, r, rb(), rb(), mk(C_LOAD, g, '0, 1'b1, 1'b0, 0, 1'b0));
        k = 0;
        for (int a = 0; a <= MAXR; a++) begin
            if (mode == 3) begin
                int p;
                p    = $urandom_range(0, 9);
                outc = (p < 6) ? 0 : (p < 9) ? 1 : 2;
                d    = $urandom_range(0, 4);
            end else begin
                outc = mode;
                d    = dly;
            end
            len = (outc == 2) ? TO : d + 1;
            for (int j = 0; j < len; j++) begin
                k++;
                if (k == abort_at) begin
                    step(1'b0, rreq(), rb(), rb(), mk(C_WAITE, '0, '0, 1'b0, 1'b0, 0, 1'b1));
                    ptr_m = 0;
                    return;
                end
                if (j < len - 1) begin
                    step(1'b1, rreq(), 1'b0, rb(), mk(C_LOAD, g, '0, 1'b0, 1'b0, a, 1'b0));
                end else if (outc == 0) begin
                    step(1'b1, rreq(), 1'b1, 1'b0, mk(C_DONE, g, g, 1'b0, 1'b0, a, 1'b1));
                    step(1'b1, rreq(), rb(), rb(), mk(C_WAITE, '0, '0, 1'b0, 1'b0, 0, 1'b0));
                    ptr_m = (owner + 1) % N;
                    return;
                end else if (a < MAXR) begin
                    step(1'b1, rreq(), outc == 1, (outc == 1) ? 1'b1 : rb(),
                         mk(C_RELOAD, g, '0, 1'b0, 1'b0, a + 1, 1'b0));
                end else begin
                    step(1'b1, rreq(), outc == 1, (outc == 1) ? 1'b1 : rb(),
                         mk(C_DONE, g, g, 1'b0, 1'b1, a, 1'b1));
                    step(1'b1, rreq(), rb(), rb(), mk(C_WAITE, '0, '0, 1'b0, 1'b0, 0, 1'b0));
                    ptr_m = (owner + 1) % N;
                    return;
                end
            end
            for (int s = 0; s < GAP; s++) begin
                k++;
                if (k == abort_at) begin
                    step(1'b0, rreq(), rb(), rb(), mk(C_WAITE, '0, '0, 1'b0, 1'b0, 0, 1'b1));
                    ptr_m = 0;
                    return;
                end
                if (s < GAP - 1)
                    step(1'b1, rreq(), rb(), rb(), mk(C_RELOAD, g, '0, 1'b0, 1'b0, a + 1, 1'b0));
                else
                    step(1'b1, rreq(), rb(), rb(), mk(C_LOAD, g, '0, 1'b1, 1'b0, a + 1, 1'b0));
            end
        end
    endtask

    logic [N-1:0] rr_order [5];

    initial begin
        bus.req = '0; bus.load_done = 1'b0; bus.load_err = 1'b0;
        rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        clear_cnt();

        // reset held two cycles with all requests up
        do_reset(2);
        chk("rst_control", 32'(bus.control), 32'h1);
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_load_start", 32'(bus.load_start), 32'h0);

        // single requester, done on the second LOAD cycle
        clear_cnt();
        run_txn(4'b0010, 0, 1, 0);
        chk("t2_starts", 32'(ls_cnt), 32'd1);
        chk("t2_acks", 32'(ack_cnt), 32'd1);
        chk("t2_ack", 32'(last_ack), 32'h2);
        chk("t2_fail", 32'(last_fail), 32'd0);
        chk("t2_retries", 32'(last_retries), 32'd0);
        chk("t2_idle", 32'(bus.control), 32'h1);

        // all requesting: strict round-robin from pointer 0
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, 0, 0, 0);
            chk("t3_rr_order", 32'(last_ack), 32'(rr_order[i]));
        end

        // every attempt errors
        clear_cnt();
        run_txn(4'b0100, 1, 0, 0);
        chk("t4_starts", 32'(ls_cnt), 32'd3);
        chk("t4_reload_cycles", 32'(reload_cyc), 32'd6);
        chk("t4_ack", 32'(last_ack), 32'h4);
        chk("t4_fail", 32'(last_fail), 32'd1);
        chk("t4_retries", 32'(last_retries), 32'd2);

        // engine never answers: three 16-cycle attempts
        clear_cnt();
        run_txn(4'b1000, 2, 0, 0);
        chk("t5_load_cycles", 32'(load_cyc), 32'd48);
        chk("t5_starts", 32'(ls_cnt), 32'd3);
        chk("t5_fail", 32'(last_fail), 32'd1);
        chk("t5_retries", 32'(last_retries), 32'd2);

        // reset lands while in RELOAD
        clear_cnt();
        run_txn(4'b0001, 1, 0, 2);
        chk("t6_reload_seen", 32'(reload_cyc), 32'd1);
        chk("t6_no_ack", 32'(ack_cnt), 32'd0);
        chk("t6_control", 32'(bus.control), 32'h1);
        chk("t6_grant", 32'(bus.grant), 32'h0);

        // randomized traffic with occasional mid-transaction resets
        for (int t = 0; t < 400; t++) begin
            int ab;
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 20)) : 0;
            run_txn(rreq(), 3, 0, ab);
        end

        @(negedge clock);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
